// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies a debounced key level into single, double, long and repeat pulses
// Ports: clk, rst (sync, active-high), key_level (1 = released, 0 = pressed),
// single_click/double_click/long_press/repeat_pulse (one-cycle registered pulses),
// busy (state not IDLE), ev_state (debug state code).
// Optional feature macro KEY_REPEAT_EN: auto-repeat pulses while a long press is held.
module key_event_decoder #(
  parameter int LONG_CYC   = 40,
  parameter int GAP_CYC    = 20,
  parameter int REPEAT_CYC = 10,
  parameter int CNT_W      = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_level,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [2:0] ev_state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    WAIT_2ND  = 3'd2,
    PRESSED2  = 3'd3,
    LONG_HELD = 3'd4
  } state_t;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYC - 1);
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             armed;
  logic             sc_n, dc_n, lp_n, rp_n;
  assign ev_state = state;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    sc_n    = 1'b0;
    dc_n    = 1'b0;
    lp_n    = 1'b0;
    rp_n    = 1'b0;
    case (state)
      IDLE: begin
        // a key held through reset must be seen released once before it counts
        if (armed && !key_level) begin
          nxt     = PRESSED;
          cnt_nxt = '0;
        end
      end
      PRESSED: begin
        if (key_level) begin
          nxt     = WAIT_2ND;
          cnt_nxt = '0;
        end else if (cnt == LONG_T) begin
          nxt     = LONG_HELD;
          cnt_nxt = '0;
          lp_n    = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      WAIT_2ND: begin
        // a press wins over the gap timeout in the same cycle
        if (!key_level) begin
          nxt     = PRESSED2;
          cnt_nxt = '0;
        end else if (cnt == GAP_T) begin
          nxt     = IDLE;
          cnt_nxt = '0;
          sc_n    = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      PRESSED2: begin
        if (key_level) begin
          nxt     = IDLE;
          cnt_nxt = '0;
          dc_n    = 1'b1;
        end else if (cnt == LONG_T) begin
          nxt     = LONG_HELD;
          cnt_nxt = '0;
          lp_n    = 1'b1;
        end else cnt_nxt = cnt + 1'b1;
      end
      LONG_HELD: begin
        if (key_level) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else if (REP_EN) begin
          // wrap at the terminal count so repeats are exactly REPEAT_CYC apart
          cnt_nxt = (cnt == REP_T) ? '0 : cnt + 1'b1;
          rp_n    = (cnt == REP_T);
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      armed        <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_nxt;
      armed        <= armed | key_level;
      single_click <= sc_n;
      double_click <= dc_n;
      long_press   <= lp_n;
      repeat_pulse <= rp_n;
      busy         <= (nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: table, hand-written and random checks of key_event_decoder against a run-length model
module tb_key_event_decoder;
  localparam int LONG_CYC   = 40;
  localparam int GAP_CYC    = 20;
  localparam int REPEAT_CYC = 10;
`ifdef KEY_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_level = 1'b1;
  logic       single_click, double_click, long_press, repeat_pulse, busy;
  logic [2:0] ev_state;
  always #5 clk = ~clk;
  key_event_decoder #(
    .LONG_CYC(LONG_CYC), .GAP_CYC(GAP_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(22)
  ) dut (
    .clk(clk), .rst(rst), .key_level(key_level),
    .single_click(single_click), .double_click(double_click),
    .long_press(long_press), .repeat_pulse(repeat_pulse),
    .busy(busy), .ev_state(ev_state)
  );
  int n_chk = 0;
  int n_fail = 0;
  int cnt_sc, cnt_dc, cnt_lp, cnt_rp;
  // model: a gesture is a sequence of level runs; events follow from run lengths
  bit   m_armed, m_act, m_long;
  int   m_run, m_nruns;
  logic m_lvl;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model(input logic v, input logic r, output logic [4:0] e);
    logic sc, dc, lp, rp;
    {sc, dc, lp, rp} = 4'b0;
    if (r) begin
      m_armed = 0; m_act = 0; m_long = 0; m_run = 0; m_nruns = 0;
    end else begin
      if (!m_act) begin
        if (m_armed && !v) begin
          m_act = 1; m_long = 0; m_run = 1; m_nruns = 0; m_lvl = 1'b0;
        end
      end else if (m_long) begin
        if (v) m_act = 0;
        else begin
          m_run++;
          if (REP == 1 && (m_run - (LONG_CYC + 1)) % REPEAT_CYC == 0) rp = 1;
        end
      end else if (v == m_lvl) begin
        m_run++;
        if (!v && m_run == LONG_CYC + 1) begin lp = 1; m_long = 1; end
        else if (v && m_run == GAP_CYC + 1) begin sc = 1; m_act = 0; end
      end else begin
        m_nruns++; m_run = 1; m_lvl = v;
        if (v && m_nruns == 3) begin dc = 1; m_act = 0; end
      end
      m_armed = m_armed | v;
    end
    e = {sc, dc, lp, rp, logic'(m_act)};
  endtask
  task automatic cyc(input logic v, input logic r);
    logic [4:0] e;
    key_level = v;
    rst = r;
    @(posedge clk);
    #1;
    model(v, r, e);
    chk("pulses_busy", int'({single_click, double_click, long_press, repeat_pulse, busy}), int'(e));
    cnt_sc += int'(single_click);
    cnt_dc += int'(double_click);
    cnt_lp += int'(long_press);
    cnt_rp += int'(repeat_pulse);
  endtask
  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) cyc(v, 1'b0);
  endtask
  task automatic zero();
    cnt_sc = 0; cnt_dc = 0; cnt_lp = 0; cnt_rp = 0;
  endtask
  typedef struct {
    int lo1, hi1, lo2, hi2;
    int sc, dc, lp, rp;
  } vec_t;
  vec_t tbl[9];
  initial begin
    int idx;
    logic lvl;
    tbl[0] = '{10, 30,  0,  0, 1, 0, 0, 0};
    tbl[1] = '{10, 20, 10, 30, 0, 1, 0, 0};
    tbl[2] = '{40, 30,  0,  0, 1, 0, 0, 0};
    tbl[3] = '{41, 30,  0,  0, 0, 0, 1, 0};
    tbl[4] = '{10,  5, 60, 30, 0, 0, 1, REP};
    tbl[5] = '{10, 21, 10, 30, 2, 0, 0, 0};
    tbl[6] = '{10, 20, 40, 30, 0, 1, 0, 0};
    tbl[7] = '{10, 20, 41, 30, 0, 0, 1, 0};
    tbl[8] = '{70, 30,  0,  0, 0, 0, 1, 2 * REP};
    zero();
    // key held low through and after reset is never reported
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    chk("reset_state", int'(ev_state), 0);
    chk("reset_busy", int'(busy), 0);
    run(1'b0, 100);
    chk("held_state", int'(ev_state), 0);
    chk("held_pulses", cnt_sc + cnt_dc + cnt_lp + cnt_rp, 0);
    run(1'b1, 5);
    for (int i = 0; i < 9; i++) begin
      zero();
      run(1'b0, tbl[i].lo1);
      run(1'b1, tbl[i].hi1);
      run(1'b0, tbl[i].lo2);
      run(1'b1, tbl[i].hi2);
      chk($sformatf("vec%0d_single", i), cnt_sc, tbl[i].sc);
      chk($sformatf("vec%0d_double", i), cnt_dc, tbl[i].dc);
      chk($sformatf("vec%0d_long", i), cnt_lp, tbl[i].lp);
      chk($sformatf("vec%0d_repeat", i), cnt_rp, tbl[i].rp);
    end
    // single click arrives on the 21st high sample, busy drops with it
    zero();
    idx = 0;
    run(1'b0, 10);
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b1, 1'b0);
      if (single_click) idx = i;
      if (i == 20) chk("busy_before_single", int'(busy), 1);
      if (i == 21) chk("busy_at_single", int'(busy), 0);
    end
    chk("single_index", idx, 21);
    chk("single_count", cnt_sc, 1);
    // long press appears right after the 41st low sample
    zero();
    for (int i = 1; i <= 41; i++) begin
      cyc(1'b0, 1'b0);
      if (i == 40) chk("long_at_40", int'(long_press), 0);
      if (i == 41) chk("long_at_41", int'(long_press), 1);
      if (i == 41) chk("long_state", int'(ev_state), 4);
    end
    run(1'b1, 30);
    chk("long_release_pulses", cnt_sc + cnt_dc + cnt_lp, 1);
    // reset in the gap aborts silently and disarms
    zero();
    run(1'b0, 10);
    run(1'b1, 5);
    chk("gap_state", int'(ev_state), 2);
    cyc(1'b1, 1'b1);
    chk("abort_state", int'(ev_state), 0);
    run(1'b0, 30);
    chk("disarmed_busy", int'(busy), 0);
    run(1'b1, 30);
    chk("abort_single", cnt_sc, 0);
    run(1'b0, 10);
    run(1'b1, 30);
    chk("rearmed_single", cnt_sc, 1);
    // random runs around every threshold, with occasional resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) cyc(1'($urandom_range(0, 1)), 1'b1);
      lvl = 1'(s % 2);
      case ($urandom_range(0, 2))
        0: run(lvl, $urandom_range(1, 12));
        1: run(lvl, $urandom_range(15, 25));
        default: run(lvl, $urandom_range(35, 75));
      endcase
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
